bus_term_port: RTL
==================

// Module: bus_term_port
// PURPOSE
//  Per-terminal hardware port between one terminal agent and the bs_gnrtr_n_rbtr bus.
//  TX side: agent writes packets into a FIFO; the bus drains it through pndng/D_pop/pop.
//  RX side: the bus delivers packets through push/D_push into an RX FIFO; the agent reads them out.
//  One instance per terminal: index [bit][terminal] of the bus pndng/pop/push/D_pop/D_push arrays.
// PARAMETERS
//  ancho_pal  16     packet width; dest ID = [ancho_pal-1 -: 8], payload = remaining LSBs
//  depth      8      entries per FIFO (TX and RX); power of 2, >=2
//  id         0      this terminal's 8-bit ID
//  broadcast  8'hFF  dest ID accepted by every terminal
// PORTS
//  clk         in   1             bus clock; all logic on posedge
//  reset       in   1             asynchronous, active-low reset
//  tx_wr       in   1             agent write strobe
//  tx_data     in   ancho_pal     packet to send
//  tx_full     out  1             TX FIFO full
//  tx_count    out  $clog2(depth)+1  TX occupancy
//  pndng       out  1             to bus: TX FIFO non-empty
//  D_pop       out  ancho_pal     to bus: TX head packet (first-word fall-through)
//  pop         in   1             from bus: consume TX head
//  push        in   1             from bus: packet delivered
//  D_push      in   ancho_pal     from bus: delivered packet
//  rx_rd       in   1             agent read strobe
//  rx_data     out  ancho_pal     RX head packet (fall-through)
//  rx_valid    out  1             RX FIFO non-empty
//  rx_ovf_cnt  out  8             RX packets dropped because RX full (saturating)
//  rx_mis_cnt  out  8             RX packets dropped for wrong dest ID (saturating)
//  err_pop     out  1             sticky: pop seen while TX empty
// BEHAVIOUR
//  Reset (reset=0, async): both FIFOs empty, pointers 0; pndng=0, tx_full=0, tx_count=0,
//   rx_valid=0, D_pop=0, rx_data=0, counters=0, err_pop=0. Reset mid-operation discards all contents.
//  FIFOs: circular buffers, wr/rd pointers with one extra wrap bit; full = MSBs differ, lower bits equal.
//  TX write: tx_wr & !tx_full -> store tx_data at wr_ptr next edge; count+1.
//   tx_wr while full and no pop -> ignored, no state change.
//   tx_wr & pop same cycle while full -> both accepted; count unchanged.
//  TX pop: pop & pndng -> rd_ptr+1 next edge; D_pop/pndng reflect new head in the same cycle the pointer updates.
//   pop while empty -> ignored, err_pop set until reset.
//   tx_wr & pop while empty -> write accepted, pop ignored, err_pop set.
//  pndng and D_pop are registered-state derived (no combinational path from pop or tx_wr).
//   Write-to-pndng latency: 1 clk.
//  RX accept: push & (D_push dest==id | dest==broadcast) & (!rx_full | rx_rd) -> store.
//   push with other dest -> dropped, rx_mis_cnt+1 (stops at 255).
//   push with matching dest while full and no rx_rd -> dropped, rx_ovf_cnt+1 (stops at 255).
//   push while rx_rd and full -> both accepted.
//  RX read: rx_rd & rx_valid -> advance head; rx_rd while empty -> ignored.
//  Counters saturate at 8'hFF and never wrap. Pointers wrap modulo depth.
// TESTING
//  1 Reset: hold reset=0 with tx_wr=1, push=1 -> all outputs 0; release -> pndng=0, rx_valid=0.
//  2 TX order: write 16'h0111,16'h0222,16'h0333, then pop x3 -> D_pop shows 0111,0222,0333 in turn;
//    pndng drops after 3rd pop; tx_count goes 3->0.
//  3 TX full/wrap: write 8 pkts -> tx_full=1; 9th write ignored; pop+write same cycle ->
//    count stays 8; drain 8 -> order preserved across pointer wrap.
//  4 RX filter (id=2): push 16'h0255, 16'hFF66, 16'h0377 -> rx_data 0255 then FF66; rx_mis_cnt=1.
//  5 RX overflow: 10 matching pushes, no rx_rd -> rx_valid=1, 8 stored, rx_ovf_cnt=2;
//    300 overflow pushes -> rx_ovf_cnt=255.
//  6 Error/reset: pop with TX empty -> err_pop=1 and stays 1; assert reset mid-traffic ->
//    FIFOs empty, err_pop=0.

Source files
------------

// File: rtl/bus_term_port.sv
// Per-terminal port between one terminal agent and the bs_gnrtr_n_rbtr bus:
// a TX FIFO drained by the bus and an RX FIFO with destination filtering.
module bus_term_port #(
   parameter int         ancho_pal = 16,
   parameter int         depth     = 8,
   parameter logic [7:0] id        = 8'd0,
   parameter logic [7:0] broadcast = 8'hFF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     tx_wr,
   input  logic [ancho_pal-1:0]     tx_data,
   output logic                     tx_full,
   output logic [$clog2(depth):0]   tx_count,
   output logic                     pndng,
   output logic [ancho_pal-1:0]     D_pop,
   input  logic                     pop,
   input  logic                     push,
   input  logic [ancho_pal-1:0]     D_push,
   input  logic                     rx_rd,
   output logic [ancho_pal-1:0]     rx_data,
   output logic                     rx_valid,
   output logic [7:0]               rx_ovf_cnt,
   output logic [7:0]               rx_mis_cnt,
   output logic                     err_pop
);

   localparam int AW = $clog2(depth);

   logic [ancho_pal-1:0] tx_mem [depth];
   logic [AW:0]          tx_wr_ptr;
   logic [AW:0]          tx_rd_ptr;
   logic                 tx_empty;
   logic                 tx_do_wr;
   logic                 tx_do_pop;

   logic [ancho_pal-1:0] rx_mem [depth];
   logic [AW:0]          rx_wr_ptr;
   logic [AW:0]          rx_rd_ptr;
   logic                 rx_empty;
   logic                 rx_full;
   logic                 rx_match;
   logic                 rx_do_wr;
   logic                 rx_do_rd;
   logic [7:0]           rx_dest;

   // Full means the pointers sit on the same slot but one lap apart.
   assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
   assign tx_full  = (tx_wr_ptr[AW] != tx_rd_ptr[AW]) &&
                     (tx_wr_ptr[AW-1:0] == tx_rd_ptr[AW-1:0]);
   assign tx_count = tx_wr_ptr - tx_rd_ptr;
   assign pndng    = !tx_empty;
   assign D_pop    = tx_empty ? '0 : tx_mem[tx_rd_ptr[AW-1:0]];

   assign tx_do_pop = pop && !tx_empty;
   assign tx_do_wr  = tx_wr && (!tx_full || tx_do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         err_pop   <= 1'b0;
         for (int i = 0; i < depth; i++) begin
            tx_mem[i] <= '0;
         end
      end else begin
         if (tx_do_wr) begin
            tx_mem[tx_wr_ptr[AW-1:0]] <= tx_data;
            tx_wr_ptr <= tx_wr_ptr + 1'b1;
         end
         if (tx_do_pop) begin
            tx_rd_ptr <= tx_rd_ptr + 1'b1;
         end
         if (pop && tx_empty) begin
            err_pop <= 1'b1;
         end
      end
   end

   assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
   assign rx_full  = (rx_wr_ptr[AW] != rx_rd_ptr[AW]) &&
                     (rx_wr_ptr[AW-1:0] == rx_rd_ptr[AW-1:0]);
   assign rx_valid = !rx_empty;
   assign rx_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr[AW-1:0]];

   assign rx_dest  = D_push[ancho_pal-1 -: 8];
   assign rx_match = (rx_dest == id) || (rx_dest == broadcast);
   assign rx_do_rd = rx_rd && !rx_empty;
   assign rx_do_wr = push && rx_match && (!rx_full || rx_do_rd);

   // A simultaneous read frees the slot that a push into a full FIFO needs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_wr_ptr  <= '0;
         rx_rd_ptr  <= '0;
         rx_ovf_cnt <= '0;
         rx_mis_cnt <= '0;
         for (int i = 0; i < depth; i++) begin
            rx_mem[i] <= '0;
         end
      end else begin
         if (rx_do_wr) begin
            rx_mem[rx_wr_ptr[AW-1:0]] <= D_push;
            rx_wr_ptr <= rx_wr_ptr + 1'b1;
         end
         if (rx_do_rd) begin
            rx_rd_ptr <= rx_rd_ptr + 1'b1;
         end
         if (push && !rx_match && (rx_mis_cnt != 8'hFF)) begin
            rx_mis_cnt <= rx_mis_cnt + 8'd1;
         end
         if (push && rx_match && !rx_do_wr && (rx_ovf_cnt != 8'hFF)) begin
            rx_ovf_cnt <= rx_ovf_cnt + 8'd1;
         end
      end
   end

endmodule
